// File: rtl/servo_pwm_gen.sv
// Fixed-period servo PWM generator; widths latched only at period boundaries.
// Define SERVO_PWM_CLAMP_EN to clamp commanded widths to [MIN_WIDTH, MAX_WIDTH].
module servo_pwm_gen #(
  parameter int PERIOD    = 2000000,
  parameter int CNT_W     = 21,
  parameter int MIN_WIDTH = 65000,
  parameter int MAX_WIDTH = 240000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [17:0] width_in,
  output logic        pwm_out,
  output logic        period_tick,
  output logic        busy,
  output logic [17:0] width_active
);

  localparam int WW    = 18;
  localparam int CMP_W = (CNT_W > WW) ? CNT_W : WW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  if (MIN_WIDTH > MAX_WIDTH || (64'(1) << CNT_W) <= 64'(PERIOD)) begin : g_bad_cfg
    $error("servo_pwm_gen: bad parameter set");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]     width_q, width_d;
  logic              pwm_q, pwm_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic              run_d;

`ifdef SERVO_PWM_CLAMP_EN
  localparam logic [WW-1:0] MIN_W = WW'(MIN_WIDTH);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WIDTH);

  // Zero is kept as an explicit "no pulse" command.
  function automatic logic [WW-1:0] sel(input logic [WW-1:0] w);
    if (w == '0)        sel = '0;
    else if (w < MIN_W) sel = MIN_W;
    else if (w > MAX_W) sel = MAX_W;
    else                sel = w;
  endfunction
`else
  function automatic logic [WW-1:0] sel(input logic [WW-1:0] w);
    sel = w;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = RUN;
          width_d = sel(width_in);
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (enable) width_d = sel(width_in);
          else        state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next state so they align with cnt_q.
  always_comb begin
    run_d  = (state_d == RUN);
    busy_d = run_d;
    tick_d = run_d && (cnt_d == '0);
    pwm_d  = run_d && (CMP_W'(cnt_d) < CMP_W'(width_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_tick  = tick_q;
  assign busy         = busy_q;
  assign width_active = width_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen with a short period.
// Period-level reference model; works with or without SERVO_PWM_CLAMP_EN.
module tb_servo_pwm_gen;

  localparam int P    = 100;
  localparam int CW   = 7;
  localparam int MINW = 5;
  localparam int MAXW = 90;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [17:0] width_in;
  logic        pwm_out;
  logic        period_tick;
  logic        busy;
  logic [17:0] width_active;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .PERIOD(P),
    .CNT_W(CW),
    .MIN_WIDTH(MINW),
    .MAX_WIDTH(MAXW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .width_in(width_in),
    .pwm_out(pwm_out),
    .period_tick(period_tick),
    .busy(busy),
    .width_active(width_active)
  );

  function automatic int sel_ref(input int w);
`ifdef SERVO_PWM_CLAMP_EN
    if (w == 0) return 0;
    if (w < MINW) return MINW;
    if (w > MAXW) return MAXW;
    return w;
`else
    return w;
`endif
  endfunction

  function automatic int hi_ref(input int w);
    int s;
    s = sel_ref(w);
    return (s > P) ? P : s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observe one full period starting in its cnt=0 cycle; no checking here.
  task automatic measure_period(
    input  int          junk_at,
    input  logic [17:0] junk_w,
    input  logic [17:0] next_w,
    input  int          en_at,
    input  logic        en_v,
    output int          hi,
    output bit          shape,
    output int          ticks,
    output bit          tick0,
    output int          busys,
    output logic [17:0] wact
  );
    logic pw [P];
    hi = 0; ticks = 0; tick0 = 0; busys = 0; wact = '0; shape = 1;
    for (int i = 0; i < P; i++) begin
      pw[i] = pwm_out;
      if (pwm_out === 1'b1) hi++;
      if (period_tick === 1'b1) begin
        ticks++;
        if (i == 0) tick0 = 1;
      end
      if (busy === 1'b1) busys++;
      if (i == P / 2) wact = width_active;
      if (i == junk_at) width_in = junk_w;
      if (i == P - 1) width_in = next_w;
      if (i == en_at) enable = en_v;
      step();
    end
    for (int i = 0; i < P; i++)
      if (pw[i] !== (i < hi)) shape = 0;
  endtask

  int hi, ticks, busys;
  bit shape, tick0;
  logic [17:0] wact;
  int cur;

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; width_in = 18'd30;
    step(); step();
    vec_cnt++;
    if ({pwm_out, period_tick, busy, width_active} !== 21'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b/%b/%b/%0d required 0/0/0/0",
               pwm_out, period_tick, busy, width_active);
    end
    enable = 1'b0;
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if ({pwm_out, period_tick, busy} !== 3'b000) begin
      err_cnt++;
      $display("FAIL idle_after_reset: got %b%b%b required 000",
               pwm_out, period_tick, busy);
    end
  endtask

  task automatic test_basic();
    width_in = 18'd30; enable = 1'b1;
    step();
    vec_cnt++;
    if ({period_tick, busy, pwm_out} !== 3'b111) begin
      err_cnt++;
      $display("FAIL start_latency: got %b%b%b required 111",
               period_tick, busy, pwm_out);
    end
    measure_period(-1, 0, 18'd30, -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 30 || !shape) begin
      err_cnt++;
      $display("FAIL basic_high: got %0d shape %0d required 30 shape 1", hi, shape);
    end
    vec_cnt++;
    if (ticks != 1 || !tick0 || busys != P || wact !== 18'd30) begin
      err_cnt++;
      $display("FAIL basic_ctl: got ticks %0d t0 %0d busy %0d wact %0d required 1 1 %0d 30",
               ticks, tick0, busys, wact, P);
    end
  endtask

  task automatic test_back_to_back();
    measure_period(-1, 0, 18'd30, -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 30 || !shape || ticks != 1 || !tick0 || busys != P) begin
      err_cnt++;
      $display("FAIL back_to_back: got hi %0d ticks %0d t0 %0d busy %0d required 30 1 1 %0d",
               hi, ticks, tick0, busys, P);
    end
  endtask

  task automatic test_boundary();
    measure_period(50, 18'd60, 18'd60, -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 30 || !shape || wact !== 18'd30) begin
      err_cnt++;
      $display("FAIL boundary_hold: got hi %0d wact %0d required 30 30", hi, wact);
    end
    measure_period(-1, 0, 18'd60, -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 60 || !shape || wact !== 18'd60) begin
      err_cnt++;
      $display("FAIL boundary_apply: got hi %0d wact %0d required 60 60", hi, wact);
    end
  endtask

  task automatic test_clamp();
    int ws [3] = '{2, 120, 0};
`ifdef SERVO_PWM_CLAMP_EN
    int ex [3] = '{5, 90, 0};
`else
    int ex [3] = '{2, 100, 0};
`endif
    measure_period(-1, 0, 18'(ws[0]), -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    for (int k = 0; k < 3; k++) begin
      measure_period(-1, 0, 18'((k < 2) ? ws[k+1] : 30), -1, 1'b1,
                     hi, shape, ticks, tick0, busys, wact);
      vec_cnt++;
      if (hi != ex[k] || !shape) begin
        err_cnt++;
        $display("FAIL clamp_w%0d: got %0d high shape %0d required %0d",
                 ws[k], hi, shape, ex[k]);
      end
    end
    cur = 30;
  endtask

  task automatic test_random();
    int nw, jw, ja;
    for (int n = 0; n < 10; n++) begin
      nw = int'($urandom_range(0, 130));
      jw = int'($urandom_range(0, 130));
      ja = int'($urandom_range(1, 97));
      measure_period(ja, 18'(jw), 18'(nw), -1, 1'b1,
                     hi, shape, ticks, tick0, busys, wact);
      vec_cnt++;
      if (hi != hi_ref(cur) || !shape || wact !== 18'(sel_ref(cur)) ||
          ticks != 1 || !tick0) begin
        err_cnt++;
        $display("FAIL random_%0d cmd %0d: got hi %0d wact %0d ticks %0d required hi %0d wact %0d ticks 1",
                 n, cur, hi, wact, ticks, hi_ref(cur), sel_ref(cur));
      end
      cur = nw;
    end
  endtask

  task automatic test_stop();
    int t, b;
    measure_period(-1, 0, 18'd30, -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    measure_period(-1, 0, 18'd30, 10, 1'b0, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 30 || !shape || busys != P) begin
      err_cnt++;
      $display("FAIL stop_full_period: got hi %0d busy %0d required 30 %0d", hi, busys, P);
    end
    vec_cnt++;
    if ({pwm_out, busy, period_tick} !== 3'b000) begin
      err_cnt++;
      $display("FAIL stop_idle: got %b%b%b required 000", pwm_out, busy, period_tick);
    end
    t = 0; b = 0;
    for (int i = 0; i < 20; i++) begin
      if (period_tick !== 1'b0) t++;
      if (busy !== 1'b0 || pwm_out !== 1'b0) b++;
      step();
    end
    vec_cnt++;
    if (t != 0 || b != 0) begin
      err_cnt++;
      $display("FAIL stop_quiet: got ticks %0d active %0d required 0 0", t, b);
    end
    enable = 1'b1;
    step();
    vec_cnt++;
    if ({period_tick, busy, pwm_out} !== 3'b111) begin
      err_cnt++;
      $display("FAIL reenable_tick: got %b%b%b required 111", period_tick, busy, pwm_out);
    end
    measure_period(-1, 0, 18'd30, -1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 30 || !shape || ticks != 1) begin
      err_cnt++;
      $display("FAIL reenable_period: got hi %0d ticks %0d required 30 1", hi, ticks);
    end
  endtask

  task automatic test_reenable_boundary();
    enable = 1'b0;
    measure_period(-1, 0, 18'd30, P - 1, 1'b1, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (busy !== 1'b1 || period_tick !== 1'b1 || hi != 30) begin
      err_cnt++;
      $display("FAIL reenable_boundary: got busy %b tick %b hi %0d required 1 1 30",
               busy, period_tick, hi);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) step();
    vec_cnt++;
    if (pwm_out !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_pwm: got %b required 1", pwm_out);
    end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({pwm_out, period_tick, busy, width_active} !== 21'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got %b/%b/%b/%0d required 0/0/0/0",
               pwm_out, period_tick, busy, width_active);
    end
    #1 rst_n = 1'b1;
    step();
    vec_cnt++;
    if ({period_tick, busy, pwm_out} !== 3'b111 || width_active !== 18'd30) begin
      err_cnt++;
      $display("FAIL restart_after_reset: got %b%b%b wact %0d required 111 30",
               period_tick, busy, pwm_out, width_active);
    end
    measure_period(-1, 0, 18'd30, P - 1, 1'b0, hi, shape, ticks, tick0, busys, wact);
    vec_cnt++;
    if (hi != 30 || !shape || ticks != 1 || !tick0) begin
      err_cnt++;
      $display("FAIL restart_period: got hi %0d ticks %0d required 30 1", hi, ticks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary();
    test_clamp();
    test_random();
    test_stop();
    test_reenable_boundary();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
